// File: rtl/full_adder_pkg.sv
// Shared constants and a reference adder model for full_adder.
package full_adder_pkg;

    localparam int DEFAULT_WIDTH = 1;
    localparam int REF_MAX_W     = 32;

    // Reference {carry,sum} for operands up to REF_MAX_W bits; the carry lands at bit [width].
    function automatic logic [REF_MAX_W:0] ref_add(input logic [REF_MAX_W-1:0] a,
                                                  input logic [REF_MAX_W-1:0] b,
                                                  input logic cin,
                                                  input int unsigned width);
        logic [REF_MAX_W-1:0] am;
        logic [REF_MAX_W-1:0] bm;
        am = a;
        bm = b;
        for (int i = 0; i < REF_MAX_W; i++) begin
            if (i >= int'(width)) begin
                am[i] = 1'b0;
                bm[i] = 1'b0;
            end
        end
        return {1'b0, am} + {1'b0, bm} + {{REF_MAX_W{1'b0}}, cin};
    endfunction

endpackage

// File: rtl/full_adder_if.sv
// Operand/result bundle for full_adder. FULL_ADDER_OVERFLOW_EN adds the overflow signal.
interface full_adder_if
    import full_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             in_valid;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             out_valid;
`ifdef FULL_ADDER_OVERFLOW_EN
    logic             overflow;

    modport master (output a, b, cin, in_valid, input sum, carry, out_valid, overflow);
    modport slave  (input a, b, cin, in_valid, output sum, carry, out_valid, overflow);
`else
    modport master (output a, b, cin, in_valid, input sum, carry, out_valid);
    modport slave  (input a, b, cin, in_valid, output sum, carry, out_valid);
`endif
endinterface

// File: rtl/full_adder_bit.sv
// Purely combinational 1-bit full-adder cell.
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);
    logic p;

    assign p     = a ^ b;
    assign sum   = p ^ cin;
    assign carry = (a & b) | (cin & p);
endmodule

// File: rtl/full_adder.sv
// Ripple-carry adder with a one-cycle registered output stage.
// Optional macro FULL_ADDER_OVERFLOW_EN adds a registered signed-overflow flag.
module full_adder
    import full_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic        clk,
    input  logic        rst,
    full_adder_if.slave bus
);
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;

    assign c[0] = bus.cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_adder_bit u_bit (
            .a     (bus.a[i]),
            .b     (bus.b[i]),
            .cin   (c[i]),
            .sum   (s[i]),
            .carry (c[i+1])
        );
    end

    logic [WIDTH-1:0] sum_d, sum_q;
    logic             carry_d, carry_q;
    logic             valid_d, valid_q;
`ifdef FULL_ADDER_OVERFLOW_EN
    logic             ovf_d, ovf_q;
`endif

    // Result registers hold across idle cycles; only out_valid pulses.
    always_comb begin
        sum_d   = sum_q;
        carry_d = carry_q;
        valid_d = bus.in_valid;
`ifdef FULL_ADDER_OVERFLOW_EN
        ovf_d   = ovf_q;
`endif
        if (bus.in_valid) begin
            sum_d   = s;
            carry_d = c[WIDTH];
`ifdef FULL_ADDER_OVERFLOW_EN
            ovf_d   = c[WIDTH] ^ c[WIDTH-1];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q   <= '0;
            carry_q <= 1'b0;
            valid_q <= 1'b0;
`ifdef FULL_ADDER_OVERFLOW_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
            valid_q <= valid_d;
`ifdef FULL_ADDER_OVERFLOW_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign bus.sum       = sum_q;
    assign bus.carry     = carry_q;
    assign bus.out_valid = valid_q;
`ifdef FULL_ADDER_OVERFLOW_EN
    assign bus.overflow  = ovf_q;
`endif
endmodule

// File: tb/tb_full_adder.sv
// Bench for full_adder at WIDTH 1, 4 and 8 against an arithmetic model plus literal vectors.
module tb_full_adder;
    import full_adder_pkg::*;

    logic clk = 1'b0;
    logic rst;
    bit   armed = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    full_adder_if #(.WIDTH(1)) if1 ();
    full_adder_if #(.WIDTH(4)) if4 ();
    full_adder_if #(.WIDTH(8)) if8 ();

    full_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    full_adder #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));
    full_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Signed overflow from the value range, not from carries.
    function automatic logic sovf(input int w, input int unsigned a, input int unsigned b, input logic cin);
        int half;
        int sa;
        int sb;
        int s;
        half = 1 << (w - 1);
        sa = (a >= half) ? int'(a) - 2 * half : int'(a);
        sb = (b >= half) ? int'(b) - 2 * half : int'(b);
        s  = sa + sb + int'(cin);
        return (s >= half) || (s < -half);
    endfunction

    function automatic logic [8:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic cin);
        logic [REF_MAX_W:0] r;
        r = ref_add(32'(a), 32'(b), cin, 8);
        return r[8:0];
    endfunction

    // Model: {carry,sum}, valid and overflow per DUT.
    logic [1:0] m1;
    logic [4:0] m4;
    logic [8:0] m8;
    logic       v1, v4, v8;
    logic       o1, o4, o8;

    always @(posedge clk) begin
        if (rst) begin
            m1 <= '0; m4 <= '0; m8 <= '0;
            v1 <= 1'b0; v4 <= 1'b0; v8 <= 1'b0;
            o1 <= 1'b0; o4 <= 1'b0; o8 <= 1'b0;
        end else begin
            v1 <= if1.in_valid;
            v4 <= if4.in_valid;
            v8 <= if8.in_valid;
            if (if1.in_valid) begin
                m1 <= 2'(if1.a) + 2'(if1.b) + 2'(if1.cin);
                o1 <= sovf(1, 32'(if1.a), 32'(if1.b), if1.cin);
            end
            if (if4.in_valid) begin
                m4 <= 5'(if4.a) + 5'(if4.b) + 5'(if4.cin);
                o4 <= sovf(4, 32'(if4.a), 32'(if4.b), if4.cin);
            end
            if (if8.in_valid) begin
                m8 <= ref8(if8.a, if8.b, if8.cin);
                o8 <= sovf(8, 32'(if8.a), 32'(if8.b), if8.cin);
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("w1_res", 64'({if1.carry, if1.sum}), 64'(m1));
            chk("w1_vld", 64'(if1.out_valid), 64'(v1));
            chk("w4_res", 64'({if4.carry, if4.sum}), 64'(m4));
            chk("w4_vld", 64'(if4.out_valid), 64'(v4));
            chk("w8_res", 64'({if8.carry, if8.sum}), 64'(m8));
            chk("w8_vld", 64'(if8.out_valid), 64'(v8));
`ifdef FULL_ADDER_OVERFLOW_EN
            chk("w1_ovf", 64'(if1.overflow), 64'(o1));
            chk("w4_ovf", 64'(if4.overflow), 64'(o4));
            chk("w8_ovf", 64'(if8.overflow), 64'(o8));
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] exp1 [8] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};

    initial begin
        rst = 1'b1;
        if1.a = '0; if1.b = '0; if1.cin = 1'b0; if1.in_valid = 1'b0;
        if4.a = '0; if4.b = '0; if4.cin = 1'b0; if4.in_valid = 1'b0;
        if8.a = '0; if8.b = '0; if8.cin = 1'b0; if8.in_valid = 1'b0;
        step();
        if4.in_valid = 1'b1;  // reset must win over a valid input
        step();
        chk("rst_w4_res", 64'({if4.carry, if4.sum}), 64'h0);
        chk("rst_w4_vld", 64'(if4.out_valid), 64'h0);
        rst = 1'b0;
        if4.in_valid = 1'b0;
        armed = 1'b1;

        // WIDTH=1 truth table
        for (int i = 0; i < 8; i++) begin
            if1.a = i[2]; if1.b = i[1]; if1.cin = i[0]; if1.in_valid = 1'b1;
            step();
            chk("w1_vec", 64'({if1.carry, if1.sum}), 64'(exp1[i]));
            chk("w1_vec_vld", 64'(if1.out_valid), 64'h1);
        end
        if1.in_valid = 1'b0;

        // WIDTH=4 boundaries
        if4.a = 4'hF; if4.b = 4'h1; if4.cin = 1'b0; if4.in_valid = 1'b1;
        step();
        chk("w4_f_1", 64'({if4.carry, if4.sum}), 64'h10);
        if4.a = 4'hF; if4.b = 4'hF; if4.cin = 1'b1;
        step();
        chk("w4_f_f_1", 64'({if4.carry, if4.sum}), 64'h1F);
`ifdef FULL_ADDER_OVERFLOW_EN
        if4.a = 4'h7; if4.b = 4'h1; if4.cin = 1'b0;
        step();
        chk("w4_ovf_71", 64'({if4.overflow, if4.carry, if4.sum}), 64'h28);
        if4.a = 4'h8; if4.b = 4'h8; if4.cin = 1'b0;
        step();
        chk("w4_ovf_88", 64'({if4.overflow, if4.carry, if4.sum}), 64'h30);
`endif

        // Hold on idle
        if4.a = 4'h3; if4.b = 4'h4; if4.cin = 1'b0; if4.in_valid = 1'b1;
        step();
        chk("w4_3_4", 64'(if4.sum), 64'h7);
        chk("w4_3_4_vld", 64'(if4.out_valid), 64'h1);
        if4.a = 4'hA; if4.in_valid = 1'b0;
        step();
        chk("w4_hold", 64'(if4.sum), 64'h7);
        chk("w4_hold_vld", 64'(if4.out_valid), 64'h0);

        // Reset beats valid, then a fresh result
        rst = 1'b1; if4.a = 4'h5; if4.b = 4'h5; if4.in_valid = 1'b1;
        step();
        chk("w4_rst_res", 64'({if4.carry, if4.sum}), 64'h0);
        chk("w4_rst_vld", 64'(if4.out_valid), 64'h0);
        rst = 1'b0; if4.a = 4'h2; if4.b = 4'h2;
        step();
        chk("w4_post_rst", 64'(if4.sum), 64'h4);
        chk("w4_post_rst_vld", 64'(if4.out_valid), 64'h1);
        if4.in_valid = 1'b0;

        // WIDTH=8 boundaries
        if8.a = 8'hFF; if8.b = 8'hFF; if8.cin = 1'b1; if8.in_valid = 1'b1;
        step();
        chk("w8_ones", 64'({if8.carry, if8.sum}), 64'h1FF);
        if8.a = 8'h00; if8.b = 8'h00; if8.cin = 1'b0;
        step();
        chk("w8_zero", 64'({if8.carry, if8.sum}), 64'h000);
        if8.a = 8'hFF; if8.b = 8'h00; if8.cin = 1'b1;
        step();
        chk("w8_wrap", 64'({if8.carry, if8.sum}), 64'h100);

        // Back-to-back random traffic; the compare process checks each cycle
        for (int n = 0; n < 1000; n++) begin
            if8.a = 8'($urandom);
            if8.b = 8'($urandom);
            if8.cin = 1'($urandom);
            if4.a = 4'($urandom);
            if4.b = 4'($urandom);
            if4.cin = 1'($urandom);
            if4.in_valid = 1'($urandom);
            step();
        end
        if8.in_valid = 1'b0;
        if4.in_valid = 1'b0;
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/full_adder.md
Name: full_adder

Overview:
- Parameterised ripple-carry adder built from 1-bit full-adder cells, with a registered output stage.
- Computes sum = a + b + cin and carry-out.
- At WIDTH=1 it is the canonical full adder: three 1-bit inputs, sum and carry outputs.
- Arithmetic leaf used by ALU and counter datapaths; one clock domain, result one cycle after valid input.

Parameters:
- WIDTH, 1, operand width in bits (>=1).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- a  input  WIDTH  operand A (unsigned).
- b  input  WIDTH  operand B (unsigned).
- cin  input  1  carry-in to bit 0.
- in_valid  input  1  a/b/cin valid this cycle.
- sum  output  WIDTH  registered sum bits.
- carry  output  1  registered carry-out of MSB.
- out_valid  output  1  sum/carry updated from a valid input last cycle.

Behaviour:
- Combinational core: ripple chain of WIDTH full_adder_bit cells.
  - Bit i: s_i = a_i ^ b_i ^ c_i; c_{i+1} = (a_i & b_i) | (c_i & (a_i ^ b_i)); c_0 = cin.
- Arithmetic: {carry, sum} = a + b + cin, computed at WIDTH+1 bits, no truncation of the carry. Operands are unsigned.
- Latency: exactly 1 cycle. If in_valid=1 at edge N, sum/carry hold the result and out_valid=1 after edge N.
- in_valid=0 at an edge: sum/carry hold their previous values; out_valid=0.
- Back-to-back: a new valid operand every cycle is accepted. There is no backpressure and no ready signal.
- Reset: rst=1 at an edge forces sum=0, carry=0 and out_valid=0 regardless of in_valid. Reset wins over a simultaneous valid input.
- Reset mid-operation: a result in flight is discarded. The first post-reset valid input yields a fresh result one cycle later.
- Outputs are glitch-free: driven only from flops.
- Boundaries:
  - All-ones + all-ones + 1 gives sum all-ones, carry 1.
  - All zeros with cin=0 gives sum 0, carry 0.
  - cin=1 with a = all-ones, b = 0 wraps: sum 0, carry 1.

Optional Feature:
- Macro FULL_ADDER_OVERFLOW_EN.
- When defined:
  - Adds output port overflow (1 bit, registered, same timing as sum).
  - overflow = signed two's-complement overflow = c_WIDTH ^ c_{WIDTH-1}.
  - At WIDTH=1, overflow = carry ^ cin.
  - Reset value 0; holds when in_valid=0.
- When undefined: port absent; no extra logic.

Decomposition:
- Package full_adder_pkg holds the default WIDTH constant and a helper function computing the reference {carry,sum} for verification.
- One natural sub-module: full_adder_bit, a purely combinational 1-bit cell (a, b, cin -> sum, carry).
  - Instantiated WIDTH times via generate with carry chained LSB to MSB.
  - Top level contains only the chain plus the output register and valid flop.

Test Plan:
- WIDTH=1, all 8 (a,b,cin) combinations with in_valid=1, checking (carry,sum) one cycle later: (0,0,0)->(0,0); (0,0,1)->(0,1); (0,1,0)->(0,1); (0,1,1)->(1,0); (1,0,0)->(0,1); (1,0,1)->(1,0); (1,1,0)->(1,0); (1,1,1)->(1,1).
- WIDTH=4:
  - a=0xF, b=0x1, cin=0 -> sum=0x0, carry=1.
  - a=0xF, b=0xF, cin=1 -> sum=0xF, carry=1.
- WIDTH=4, apply a=0x3, b=0x4 with in_valid=1, then in_valid=0 with a=0xA -> sum stays 0x7, out_valid drops to 0.
- Assert rst together with in_valid=1 (a=0x5, b=0x5) -> next cycle sum=0, carry=0, out_valid=0. Next valid input (0x2+0x2) -> sum=0x4 one cycle later.
- With FULL_ADDER_OVERFLOW_EN, WIDTH=4:
  - a=0x7, b=0x1, cin=0 -> sum=0x8, overflow=1, carry=0.
  - a=0x8, b=0x8 -> sum=0x0, carry=1, overflow=1.
- Random regression: 1000 back-to-back valid cycles, WIDTH=8. Each output compared to the package reference function delayed one cycle.
